uart_receive_cfg: RTL

Parametrised UART receiver: a successor to the fixed 8N1 receiver, for the keychain serial links. It deserialises an asynchronous serial line into configurable-width words:
- 5–9 data bits, 1 or 2 stop bits, optional parity.
- Input synchroniser, plus framing and parity error reporting.
- A one-word output holding register with a valid/ready handshake and overrun detection.

It sits between the board RX pin and the command decoder or FIFO.

---
 rtl/uart_receive_cfg.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_receive_cfg.sv
// uart_receive_cfg
// ----------------
// Configurable UART receiver. It turns an asynchronous serial line into
// DATA_BITS-wide words (LSB first) with 1 or 2 stop bits and optional parity.
// Each finished frame goes into a one-word holding register that the consumer
// drains with a valid/ready handshake. The framing and parity flags qualify
// the held word.
//
// Compile-time option:
//   UART_RX_PARITY_EN - when defined, a parity bit is expected between the
//                       data and stop bits, and it is checked according to
//                       PARITY_ODD. When undefined, parity_err_out is
//                       always 0.
//
// Ports:
//   clk_in         system clock
//   rst_in         asynchronous active-high reset
//   rx_wire_in     raw serial line, idles high, asynchronous to clk_in
//   ready_in       consumer accepts the held word
//   valid_out      held word available
//   data_out       received word
//   frame_err_out  a stop bit of the held word was sampled low
//   parity_err_out the held word failed its parity check
//   overrun_out    one-cycle pulse when a finished frame is dropped
module uart_receive_cfg #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int STOP_BITS        = 1,
  parameter int PARITY_ODD       = 0
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_wire_in,
  input  logic                 ready_in,
  output logic                 valid_out,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_err_out,
  output logic                 parity_err_out,
  output logic                 overrun_out
);

  localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BAUD       = BAUD_BIT_PERIOD / 2;
  localparam int CW              = (BAUD_BIT_PERIOD > 2) ? $clog2(BAUD_BIT_PERIOD) : 1;
  localparam int IW              = $clog2(DATA_BITS);

  localparam logic [CW-1:0] HALF_CNT  = CW'(HALF_BAUD);
  localparam logic [CW-1:0] LAST_CNT  = CW'(BAUD_BIT_PERIOD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    DELIVER = 3'd5
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [IW-1:0]        index;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 frame_err;
  logic                 parity_err;
  logic                 rx_meta;
  logic                 rx_s;

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_IS_ODD = (PARITY_ODD != 0);
`else
  // PARITY_ODD has no effect without the parity stage.
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  // Two-flop synchroniser. Both flops reset to the idle line level, so a
  // reset can never look like a start bit.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_wire_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      count          <= '0;
      index          <= '0;
      stop_idx       <= 1'b0;
      shift          <= '0;
      frame_err      <= 1'b0;
      parity_err     <= 1'b0;
      valid_out      <= 1'b0;
      data_out       <= '0;
      frame_err_out  <= 1'b0;
      parity_err_out <= 1'b0;
      overrun_out    <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      // Handshake completes this cycle. DELIVER below may set valid again.
      if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end

      case (state)
        IDLE: begin
          count      <= '0;
          index      <= '0;
          stop_idx   <= 1'b0;
          frame_err  <= 1'b0;
          parity_err <= 1'b0;
          if (!rx_s) begin
            state <= START;
          end
        end

        // Check the start bit again at mid-bit to reject glitches.
        START: begin
          if (count == HALF_CNT) begin
            count <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            count <= count + 1'b1;
          end
        end

        DATA: begin
          if (count == LAST_CNT) begin
            count        <= '0;
            shift[index] <= rx_s;
            if (index == LAST_IDX) begin
              index <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (count == LAST_CNT) begin
            count      <= '0;
            parity_err <= (((^shift) ^ rx_s) != PARITY_IS_ODD);
            state      <= STOP;
          end else begin
            count <= count + 1'b1;
          end
        end
`endif

        // Leave after the last mid-bit sample. Not waiting for the end of
        // the stop bit lets the next start bit follow immediately.
        STOP: begin
          if (count == LAST_CNT) begin
            count <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
            end
            if (stop_idx == LAST_STOP) begin
              state <= DELIVER;
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end

        // The holding register is free if it is empty or being drained now.
        DELIVER: begin
          state <= IDLE;
          if (!valid_out || ready_in) begin
            valid_out      <= 1'b1;
            data_out       <= shift;
            frame_err_out  <= frame_err;
            parity_err_out <= parity_err;
          end else begin
            overrun_out <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
